// File: rtl/pr_bus_ctrl.sv
// rtl/pr_bus_ctrl.sv - Pr* bridge bus controller: decode, select/ready handshake with timeout, IRQ staging
module pr_bus_ctrl #(
  parameter int          NDEV     = 3,
  parameter logic [31:0] BASE     = 32'h00007F00,
  parameter int          WIN_LOG2 = 4,
  parameter int          TIMEOUT  = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_pr_req,
  input  logic [29:0]           i_pr_addr,
  input  logic [3:0]            i_pr_be,
  input  logic [31:0]           i_pr_wd,
  input  logic                  i_pr_we,
  output logic [31:0]           o_pr_rd,
  output logic                  o_pr_stall,
  output logic                  o_pr_err,
  output logic [NDEV-1:0]       o_dev_sel,
  output logic [WIN_LOG2-3:0]   o_dev_addr,
  output logic [31:0]           o_dev_wd,
  output logic [3:0]            o_dev_be,
  output logic                  o_dev_we,
  input  logic [NDEV*32-1:0]    i_dev_rd,
  input  logic [NDEV-1:0]       i_dev_rdy,
  input  logic [NDEV-1:0]       i_dev_irq,
  output logic [5:0]            o_hw_int
);

  localparam int AW = WIN_LOG2 - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  state_t              r_state;
  logic [2:0]          r_idx;
  logic                r_we;
  logic [7:0]          r_cnt;
  logic [31:0]         r_pr_rd;
  logic                r_pr_err;
  logic [NDEV-1:0]     r_dev_sel;
  logic [AW-1:0]       r_dev_addr;
  logic [31:0]         r_dev_wd;
  logic [3:0]          r_dev_be;
  logic                r_dev_we;
  logic [5:0]          r_hw_int;

  logic [29:0]         w_off;
  logic [29:0]         w_idx;
  logic                w_hit;
  logic [NDEV-1:0]     w_sel_onehot;
  logic [31:0]         w_rd_sel;
  logic                w_rdy_sel;
  logic [5:0]          w_irq_pad;

  // Address decode: word offset from BASE, slot index and hit test (wraps below BASE to a miss)
  always_comb begin
    w_off        = i_pr_addr - BASE[31:2];
    w_idx        = w_off >> AW;
    w_hit        = (w_idx < 30'(NDEV));
    w_sel_onehot = '0;
    for (int i = 0; i < NDEV; i++) begin
      w_sel_onehot[i] = (w_idx == 30'(i));
    end
  end

  // Pick read data and ready of the latched slot; other slots' ready is ignored
  always_comb begin
    w_rd_sel  = '0;
    w_rdy_sel = 1'b0;
    for (int i = 0; i < NDEV; i++) begin
      if (r_idx == 3'(i)) begin
        w_rd_sel  = i_dev_rd[32*i +: 32];
        w_rdy_sel = i_dev_rdy[i];
      end
    end
  end

  // Zero-extend device interrupts onto the six CPU interrupt lines
  always_comb begin
    w_irq_pad              = '0;
    w_irq_pad[NDEV-1:0]    = i_dev_irq;
  end

  // Main access sequencer with registered bus outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_cnt      <= '0;
      r_pr_rd    <= '0;
      r_pr_err   <= 1'b0;
      r_dev_sel  <= '0;
      r_dev_addr <= '0;
      r_dev_wd   <= '0;
      r_dev_be   <= '0;
      r_dev_we   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_pr_req) begin
            if (w_hit) begin
              r_state    <= S_ACCESS;
              r_idx      <= w_idx[2:0];
              r_we       <= i_pr_we;
              r_cnt      <= '0;
              r_dev_sel  <= w_sel_onehot;
              r_dev_addr <= w_off[AW-1:0];
              r_dev_wd   <= i_pr_wd;
              r_dev_be   <= i_pr_be;
              r_dev_we   <= i_pr_we;
            end else begin
              r_state  <= S_ERROR;
              r_pr_err <= 1'b1;
              r_pr_rd  <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (w_rdy_sel) begin
            r_state   <= S_DONE;
            r_pr_rd   <= r_we ? 32'd0 : w_rd_sel;
            r_dev_sel <= '0;
            r_dev_we  <= 1'b0;
          end else if (r_cnt == 8'(TIMEOUT - 1)) begin
            r_state   <= S_ERROR;
            r_pr_err  <= 1'b1;
            r_pr_rd   <= '0;
            r_dev_sel <= '0;
            r_dev_we  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          // A request still present here belongs to the instruction just completed
          r_state <= S_IDLE;
          r_pr_rd <= '0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_pr_err <= 1'b0;
          r_pr_rd  <= '0;
        end
      endcase
    end
  end

  // One flop stage on the interrupt lines, independent of the sequencer
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hw_int <= '0;
    end else begin
      r_hw_int <= w_irq_pad;
    end
  end

  assign o_pr_stall = (r_state == S_IDLE) ? i_pr_req : (r_state == S_ACCESS);
  assign o_pr_rd    = r_pr_rd;
  assign o_pr_err   = r_pr_err;
  assign o_dev_sel  = r_dev_sel;
  assign o_dev_addr = r_dev_addr;
  assign o_dev_wd   = r_dev_wd;
  assign o_dev_be   = r_dev_be;
  assign o_dev_we   = r_dev_we;
  assign o_hw_int   = r_hw_int;

endmodule

// File: tb/tb_pr_bus_ctrl.sv
// tb/tb_pr_bus_ctrl.sv - self-checking bench for pr_bus_ctrl
module tb_pr_bus_ctrl;

  localparam int          NDEV    = 3;
  localparam logic [31:0] BASE    = 32'h00007F00;
  localparam int          TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         pr_req;
  logic [29:0]  pr_addr;
  logic [3:0]   pr_be;
  logic [31:0]  pr_wd;
  logic         pr_we;
  logic [31:0]  pr_rd;
  logic         pr_stall;
  logic         pr_err;
  logic [2:0]   dev_sel;
  logic [1:0]   dev_addr;
  logic [31:0]  dev_wd;
  logic [3:0]   dev_be;
  logic         dev_we;
  logic [95:0]  dev_rd;
  logic [2:0]   dev_rdy;
  logic [2:0]   dev_irq;
  logic [5:0]   hw_int;

  int errors = 0;
  int checks = 0;

  pr_bus_ctrl #(.NDEV(NDEV), .BASE(BASE), .WIN_LOG2(4), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(reset), .i_pr_req(pr_req), .i_pr_addr(pr_addr),
    .i_pr_be(pr_be), .i_pr_wd(pr_wd), .i_pr_we(pr_we), .o_pr_rd(pr_rd),
    .o_pr_stall(pr_stall), .o_pr_err(pr_err), .o_dev_sel(dev_sel),
    .o_dev_addr(dev_addr), .o_dev_wd(dev_wd), .o_dev_be(dev_be), .o_dev_we(dev_we),
    .i_dev_rd(dev_rd), .i_dev_rdy(dev_rdy), .i_dev_irq(dev_irq), .o_hw_int(hw_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU access; rdy_delay = ACCESS cycle on which the selected slot raises ready (0 = never)
  task automatic run_access(input string name, input logic [29:0] addr, input logic we,
                            input logic [31:0] wd, input logic [3:0] be, input int rdy_delay);
    logic [31:0] byte_off;
    int unsigned slot;
    int unsigned word;
    bit hit;
    bit completes;
    int acc;
    int stalls;
    logic [31:0] slot_data;
    logic [2:0] rdy;
    byte_off  = {addr, 2'b00} - BASE;
    slot      = byte_off / 16;
    word      = (byte_off % 16) / 4;
    hit       = (slot < NDEV);
    completes = hit && rdy_delay >= 1 && rdy_delay <= TIMEOUT;
    acc       = !hit ? 0 : (completes ? rdy_delay : TIMEOUT);
    stalls    = 0;
    slot_data = 32'd0;

    @(negedge clk);
    dev_rd  = {$urandom, $urandom, $urandom};
    dev_rdy = 3'($urandom);
    pr_req  = 1'b1; pr_addr = addr; pr_we = we; pr_wd = wd; pr_be = be;
    if (hit) slot_data = dev_rd[32*slot +: 32];
    #1;
    chk({name, ".req_stall"}, 32'(pr_stall), 32'd1);
    chk({name, ".req_sel"}, 32'(dev_sel), 32'd0);
    stalls += int'(pr_stall);

    for (int k = 1; k <= acc; k++) begin
      @(negedge clk);
      pr_addr = 30'($urandom);
      pr_wd   = $urandom;
      rdy     = 3'($urandom);
      rdy[slot] = (k == rdy_delay);
      dev_rdy = rdy;
      #1;
      chk({name, ".acc_sel"}, 32'(dev_sel), 32'd1 << slot);
      chk({name, ".acc_we"}, 32'(dev_we), 32'(we));
      chk({name, ".acc_addr"}, 32'(dev_addr), word);
      chk({name, ".acc_wd"}, dev_wd, wd);
      chk({name, ".acc_be"}, 32'(dev_be), 32'(be));
      chk({name, ".acc_err"}, 32'(pr_err), 32'd0);
      stalls += int'(pr_stall);
    end

    @(negedge clk);
    dev_rdy = 3'($urandom);
    pr_addr = 30'($urandom);
    #1;
    stalls += int'(pr_stall);
    chk({name, ".end_sel"}, 32'(dev_sel), 32'd0);
    chk({name, ".end_we"}, 32'(dev_we), 32'd0);
    if (completes) begin
      chk({name, ".done_err"}, 32'(pr_err), 32'd0);
      chk({name, ".done_rd"}, pr_rd, we ? 32'd0 : slot_data);
    end else begin
      chk({name, ".err_pulse"}, 32'(pr_err), 32'd1);
      chk({name, ".err_rd"}, pr_rd, 32'd0);
    end
    chk({name, ".stall_cycles"}, 32'(stalls), 32'(1 + acc));

    @(negedge clk);
    pr_req = 1'b0;
    #1;
    chk({name, ".after_stall"}, 32'(pr_stall), 32'd0);
    chk({name, ".after_err"}, 32'(pr_err), 32'd0);
    chk({name, ".after_sel"}, 32'(dev_sel), 32'd0);
    chk({name, ".after_rd"}, pr_rd, 32'd0);
  endtask

  initial begin
    logic [2:0] prev_irq;
    reset = 1'b1; pr_req = 1'b0; pr_addr = '0; pr_be = '0; pr_wd = '0; pr_we = 1'b0;
    dev_rd = '0; dev_rdy = '0; dev_irq = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.rd", pr_rd, 32'd0);
    chk("rst.err", 32'(pr_err), 32'd0);
    chk("rst.sel", 32'(dev_sel), 32'd0);
    chk("rst.we", 32'(dev_we), 32'd0);
    chk("rst.wd", dev_wd, 32'd0);
    chk("rst.be", 32'(dev_be), 32'd0);
    chk("rst.addr", 32'(dev_addr), 32'd0);
    chk("rst.hwint", 32'(hw_int), 32'd0);
    chk("rst.stall", 32'(pr_stall), 32'd0);

    // Directed cases
    run_access("rd_slot1", 30'(32'h7F14 >> 2), 1'b0, 32'h0, 4'hF, 1);
    run_access("wr_slot0", 30'(32'h7F08 >> 2), 1'b1, 32'hA5A5A5A5, 4'hF, 3);
    run_access("miss", 30'(32'h7F30 >> 2), 1'b0, 32'h0, 4'h0, 1);
    run_access("below_base", 30'(32'h7EFC >> 2), 1'b1, 32'h1, 4'h1, 1);
    run_access("timeout", 30'(32'h7F2C >> 2), 1'b0, 32'h0, 4'hF, 0);
    run_access("rdy_last", 30'(32'h7F24 >> 2), 1'b0, 32'h0, 4'h3, TIMEOUT);

    // Reset during the second ACCESS cycle
    @(negedge clk);
    pr_req = 1'b1; pr_addr = 30'(32'h7F18 >> 2); pr_we = 1'b1; pr_wd = 32'hDEADBEEF; pr_be = 4'hC;
    dev_rdy = 3'b000;
    @(negedge clk);
    #1;
    chk("rstmid.sel1", 32'(dev_sel), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid.sel2", 32'(dev_sel), 32'd2);
    @(negedge clk);
    reset = 1'b0; pr_req = 1'b0;
    #1;
    chk("rstmid.sel", 32'(dev_sel), 32'd0);
    chk("rstmid.we", 32'(dev_we), 32'd0);
    chk("rstmid.stall", 32'(pr_stall), 32'd0);
    chk("rstmid.err", 32'(pr_err), 32'd0);
    chk("rstmid.wd", dev_wd, 32'd0);
    @(negedge clk);
    #1;
    chk("rstmid.err2", 32'(pr_err), 32'd0);
    chk("rstmid.rd2", pr_rd, 32'd0);

    // Interrupt staging
    @(negedge clk);
    dev_irq = 3'b101;
    #1;
    chk("irq.before", 32'(hw_int), 32'd0);
    @(negedge clk);
    #1;
    chk("irq.after", 32'(hw_int), 32'b000101);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("irq.reset", 32'(hw_int), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("irq.release", 32'(hw_int), 32'b000101);
    prev_irq = dev_irq;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("irq.rand", 32'(hw_int), 32'(prev_irq));
      dev_irq  = 3'($urandom);
      prev_irq = dev_irq;
    end
    dev_irq = '0;

    // Randomized accesses, mostly near the device windows
    for (int i = 0; i < 40; i++) begin
      logic [29:0] a;
      if ($urandom_range(0, 7) == 0) a = 30'($urandom);
      else a = 30'((BASE >> 2) + 32'($urandom_range(0, 4 * (NDEV + 1) - 1)));
      run_access("rand", a, 1'($urandom), $urandom, 4'($urandom),
                 int'($urandom_range(0, TIMEOUT + 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
